// File: rtl/f_pc_gen_pkg.sv
// Shared fetch/decode constants: next-PC opcodes and default reset/exception addresses.
package f_pc_gen_pkg;
  localparam logic [2:0] NPC_PLUS4   = 3'b000;
  localparam logic [2:0] NPC_BRANCH  = 3'b001;
  localparam logic [2:0] NPC_JUMP    = 3'b010;
  localparam logic [2:0] NPC_JUMPREG = 3'b011;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
endpackage

// File: rtl/f_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry, underflow is ignored.
module f_ras #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [31:0]   i_push_dat,
  output logic [31:0]   o_top,
  output logic [CW-1:0] o_count
);
  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_tos;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_tos_inc;
  logic          w_empty;
  logic          w_full;

  assign w_tos_inc = r_tos + PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tos <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_push && i_pop) begin
      // JALR: the return consumes the top slot and the call refills it
      r_mem[r_tos] <= i_push_dat;
      if (w_empty) r_cnt <= CW'(1);
    end else if (i_push) begin
      r_tos            <= w_tos_inc;
      r_mem[w_tos_inc] <= i_push_dat;
      if (!w_full) r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !w_empty) begin
      r_tos <= r_tos - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_top   = w_empty ? '0 : r_mem[r_tos];
  assign o_count = r_cnt;
endmodule

// File: rtl/f_pc_gen.sv
// Fetch-stage PC register with prioritised next-PC select, return-address stack and fetch address check.
module f_pc_gen
  import f_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE    = 32'h0000_4000,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_f,
  input  logic [2:0]                   npc_op,
  input  logic                         branch_taken,
  input  logic [31:0]                  pc_d,
  input  logic [31:0]                  offset,
  input  logic [25:0]                  instr_index,
  input  logic [31:0]                  reg_data,
  input  logic                         is_call_d,
  input  logic                         exc_req,
  input  logic                         eret_req,
  input  logic [31:0]                  epc,
  output logic [31:0]                  pc_f,
  output logic                         adel_f,
  output logic [31:0]                  ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_hit
);
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [32:0] w_im_end;
  logic        w_ras_en;
  logic        w_is_jr;

  assign w_is_jr = (npc_op == NPC_JUMPREG);

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (exc_req)                                   w_next_pc = EXC_VECTOR;
    else if (eret_req)                             w_next_pc = epc;
    else if (stall_f)                              w_next_pc = r_pc;
    else if (npc_op == NPC_JUMP)                   w_next_pc = {pc_d[31:28], instr_index, 2'b00};
    else if (w_is_jr)                              w_next_pc = reg_data;
    else if (npc_op == NPC_BRANCH && branch_taken) w_next_pc = pc_d + 32'd4 + (offset << 2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_next_pc;
  end

  // 33-bit bound so a window ending at 2^32 does not wrap
  assign w_im_end = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
  assign adel_f   = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || ({1'b0, r_pc} >= w_im_end);
  assign pc_f     = r_pc;

  assign w_ras_en = !stall_f && !exc_req && !eret_req;

  f_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (reset),
    .i_push    (w_ras_en && is_call_d),
    .i_pop     (w_ras_en && w_is_jr),
    .i_clear   (exc_req),
    .i_push_dat(pc_d + 32'd8),
    .o_top     (ras_top),
    .o_count   (ras_count)
  );

  assign ras_hit = w_is_jr && (ras_count != '0) && (ras_top == reg_data);
endmodule

// File: tb/tb_f_pc_gen.sv
// Directed test-plan steps followed by random traffic, checked against a queue-based reference model.
module tb_f_pc_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic [2:0]  npc_op;
  logic        branch_taken;
  logic [31:0] pc_d;
  logic [31:0] offset;
  logic [25:0] instr_index;
  logic [31:0] reg_data;
  logic        is_call_d;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic        adel_f;
  logic [31:0] ras_top;
  logic [2:0]  ras_count;
  logic        ras_hit;

  f_pc_gen dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .npc_op(npc_op),
    .branch_taken(branch_taken), .pc_d(pc_d), .offset(offset),
    .instr_index(instr_index), .reg_data(reg_data), .is_call_d(is_call_d),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .pc_f(pc_f),
    .adel_f(adel_f), .ras_top(ras_top), .ras_count(ras_count), .ras_hit(ras_hit)
  );

  always #5 clk = ~clk;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_adel(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000) || (p >= 32'h3000 + 32'h4000);
  endfunction

  function logic [31:0] m_top();
    return (m_ras.size() != 0) ? m_ras[$] : 32'h0;
  endfunction

  function logic m_hit();
    return (npc_op == 3'd3) && (m_ras.size() != 0) && (m_top() == reg_data);
  endfunction

  task model_reset();
    m_pc = 32'h3000;
    m_ras.delete();
  endtask

  task model_edge();
    logic push, pop;
    push = 1'b0;
    pop  = 1'b0;
    if (exc_req) begin
      m_pc = 32'h4180;
      m_ras.delete();
    end else if (eret_req) begin
      m_pc = epc;
    end else if (!stall_f) begin
      push = is_call_d;
      pop  = (npc_op == 3'd3);
      case (npc_op)
        3'd2:    m_pc = {pc_d[31:28], instr_index, 2'b00};
        3'd3:    m_pc = reg_data;
        3'd1:    m_pc = branch_taken ? pc_d + 4 + offset * 4 : m_pc + 4;
        default: m_pc = m_pc + 4;
      endcase
    end
    if (push && pop) begin
      if (m_ras.size() == 0) m_ras.push_back(pc_d + 8);
      else m_ras[m_ras.size() - 1] = pc_d + 8;
    end else if (push) begin
      m_ras.push_back(pc_d + 8);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (pop && m_ras.size() != 0) begin
      void'(m_ras.pop_back());
    end
  endtask

  task idle();
    stall_f = 0; npc_op = 0; branch_taken = 0; pc_d = 0; offset = 0;
    instr_index = 0; reg_data = 0; is_call_d = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  // One clock: check combinational hit before the edge, state after it.
  task cyc();
    #1;
    chk("ras_hit", {31'b0, ras_hit}, {31'b0, m_hit()});
    @(posedge clk);
    model_edge();
    #1;
    chk("pc_f", pc_f, m_pc);
    chk("adel_f", {31'b0, adel_f}, {31'b0, m_adel(m_pc)});
    chk("ras_top", ras_top, m_top());
    chk("ras_count", {29'b0, ras_count}, m_ras.size());
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    model_reset();
    chk("rst_pc", pc_f, 32'h3000);
    chk("rst_adel", {31'b0, adel_f}, 32'h0);
    chk("rst_top", ras_top, 32'h0);
    chk("rst_count", {29'b0, ras_count}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    repeat (3) cyc();
    chk("tp_seq_pc", pc_f, 32'h300C);

    npc_op = 3'd1; pc_d = 32'h3010; branch_taken = 1; offset = 32'hFFFF_FFFE;
    cyc();
    chk("tp_branch_taken", pc_f, 32'h300C);
    branch_taken = 0;
    cyc();
    chk("tp_branch_not_taken", pc_f, 32'h3010);

    idle(); stall_f = 1; npc_op = 3'd2; instr_index = 26'h0000C40;
    cyc();
    chk("tp_stall_hold", pc_f, 32'h3010);
    exc_req = 1;
    cyc();
    chk("tp_exc_pc", pc_f, 32'h4180);
    chk("tp_exc_count", {29'b0, ras_count}, 32'h0);

    idle();
    for (int i = 0; i < 5; i++) begin
      npc_op = 3'd2; is_call_d = 1; instr_index = 26'h0000C00; pc_d = 32'h3000 + 16 * i;
      cyc();
    end
    chk("tp_jal_count", {29'b0, ras_count}, 32'h4);
    chk("tp_jal_top", ras_top, 32'h3048);

    idle();
    for (int i = 0; i < 4; i++) begin
      npc_op = 3'd3; reg_data = 32'h3048 - 16 * i;
      #1 chk("tp_jr_hit", {31'b0, ras_hit}, 32'h1);
      chk("tp_jr_top", ras_top, 32'h3048 - 16 * i);
      cyc();
    end
    reg_data = 32'h3008;
    #1 chk("tp_jr_underflow_hit", {31'b0, ras_hit}, 32'h0);
    cyc();
    chk("tp_jr_underflow_count", {29'b0, ras_count}, 32'h0);

    idle(); npc_op = 3'd2; is_call_d = 1; instr_index = 26'h0000C00;
    pc_d = 32'h3050; cyc();
    pc_d = 32'h3060; cyc();
    npc_op = 3'd3; pc_d = 32'h3100; reg_data = 32'h3200;
    cyc();
    chk("tp_jalr_pc", pc_f, 32'h3200);
    chk("tp_jalr_top", ras_top, 32'h3108);
    chk("tp_jalr_count", {29'b0, ras_count}, 32'h2);

    idle(); eret_req = 1; epc = 32'h3002;
    cyc();
    chk("tp_eret_pc", pc_f, 32'h3002);
    chk("tp_eret_adel", {31'b0, adel_f}, 32'h1);
    idle(); npc_op = 3'd3; reg_data = 32'h7000;
    cyc();
    chk("tp_jr_high_adel", {31'b0, adel_f}, 32'h1);

    // asynchronous reset in the middle of a stalled redirect
    idle(); stall_f = 1; npc_op = 3'd2; instr_index = 26'h0000C40;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_pc", pc_f, 32'h3000);
    chk("async_rst_count", {29'b0, ras_count}, 32'h0);
    chk("async_rst_top", ras_top, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    for (int i = 0; i < 400; i++) begin
      stall_f      = ($urandom_range(0, 4) == 0);
      exc_req      = ($urandom_range(0, 15) == 0);
      eret_req     = ($urandom_range(0, 15) == 0);
      npc_op       = 3'($urandom_range(0, 7));
      branch_taken = 1'($urandom_range(0, 1));
      is_call_d    = ($urandom_range(0, 2) == 0);
      pc_d         = 32'h3000 + 4 * $urandom_range(0, 4095);
      offset       = $urandom;
      instr_index  = 26'($urandom);
      epc          = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095);
      reg_data     = ($urandom_range(0, 1) == 1 && m_ras.size() != 0) ? m_top()
                                                                      : 32'h3000 + 4 * $urandom_range(0, 4095);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/f_pc_gen.md
Name: f_pc_gen

Overview:
Parametrised fetch-stage PC generator. It holds the F-stage PC register and selects the next PC from sequential, branch, jump, jump-register, exception-vector and ERET sources, with a fixed priority. It adds a return-address stack (RAS) that tracks call/return depth for JR prediction statistics and exposes a fetch address-error flag. It sits between the D-stage decode/compare logic and instruction memory.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VECTOR, 32'h0000_4180, exception entry address
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_SIZE, 32'h0000_4000, bytes of legal fetch space starting at IM_BASE
RAS_DEPTH, 4, number of RAS entries (power of two, at least 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
stall_f  in  1  freeze PC and RAS (hazard stall)
npc_op  in  3  000 plus4, 001 branch, 010 jump, 011 jump-reg; others treated as plus4
branch_taken  in  1  D-stage compare result
pc_d  in  32  PC of the instruction in D
offset  in  32  sign-extended branch immediate (word units)
instr_index  in  26  J-type target field
reg_data  in  32  forwarded rs value for JR/JALR
is_call_d  in  1  D instruction is JAL/JALR
exc_req  in  1  exception or interrupt taken this cycle
eret_req  in  1  ERET in D
epc  in  32  return address for ERET
pc_f  out  32  current fetch PC
adel_f  out  1  fetch address error
ras_top  out  32  current RAS top entry (0 when empty)
ras_count  out  $clog2(RAS_DEPTH)+1  valid entries
ras_hit  out  1  current JR target equals ras_top and the RAS is non-empty

Behaviour:
- Reset is asynchronous: pc_f=RESET_PC, RAS entries=0, ras_count=0; all outputs are derived from these values.
- next_pc priority, highest first:
  1. exc_req: EXC_VECTOR.
  2. eret_req: epc.
  3. stall_f: hold pc_f.
  4. npc_op=010: {pc_d[31:28], instr_index, 2'b00}.
  5. npc_op=011: reg_data.
  6. npc_op=001 and branch_taken: pc_d+4+(offset<<2), 32-bit wrap.
  7. Otherwise: pc_f+4, 32-bit wrap.
- pc_f <= next_pc on every clk rising edge. Single-cycle latency from any input to pc_f.
- adel_f (combinational) = pc_f[1:0]!=0, or pc_f<IM_BASE, or pc_f>=IM_BASE+IM_SIZE.
- RAS operations are gated by !stall_f && !exc_req && !eret_req.
  - push = is_call_d. The pushed value is pc_d+8, the return address past the delay slot.
  - pop = npc_op==011.
  - push only: write at tos+1 with circular wrap. On overflow (count==RAS_DEPTH) the oldest entry is silently overwritten and count stays saturated.
  - pop only: tos-1 and count-1. On underflow (count==0) nothing changes.
  - push and pop together (JALR): top entry is replaced with pc_d+8; count is unchanged, or becomes 1 if it was 0.
- exc_req also clears the RAS (count=0) on the same edge.
- ras_hit = (npc_op==011) && count!=0 && ras_top==reg_data. It is combinational, advisory only, and never changes next_pc.
- A reset asserted mid-stall or mid-redirect overrides everything immediately.

Decomposition:
- Shared package holds the NPC opcode constants (PLUS4, BRANCH, JUMP, JUMPREG) and the default RESET_PC and EXC_VECTOR values. The D-stage controller uses the same constants.
- One sub-module, f_ras: a circular stack with push, pop, clear, top and count, parametrised by RAS_DEPTH.

Test Plan:
- Reset then 3 free-running cycles -> pc_f 0x3000, 0x3004, 0x3008, 0x300C; adel_f=0.
- pc_d=0x3010, npc_op=001, branch_taken=1, offset=0xFFFFFFFE -> pc_f=0x300C next cycle. Same stimulus with branch_taken=0 -> pc_f+4.
- stall_f=1 together with npc_op=010 -> pc_f held and ras_count unchanged. Same stimulus with exc_req=1 -> pc_f=0x4180 and ras_count=0.
- 5 JALs with pc_d=0x3000, 0x3010, 0x3020, 0x3030, 0x3040, RAS_DEPTH=4 -> ras_count=4, ras_top=0x3048. Then 4 JRs with matching reg_data -> ras_hit=1 each time, tops 0x3048, 0x3038, 0x3028, 0x3018. A 5th JR -> count stays 0 and ras_hit=0.
- JALR with count=2, pc_d=0x3100, reg_data=0x3200 -> pc_f=0x3200, ras_top=0x3108, count=2.
- eret_req=1 with epc=0x3002 -> pc_f=0x3002, adel_f=1. Then reg_data=0x7000 via JR -> adel_f=1.
